// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared read-mode constants and pointer-wrap helper for fifo_flex.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Explicit compare so that non-power-of-two depths wrap correctly.
    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : 1W/1R register file, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 5,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flex
// Description : Single-clock FIFO, arbitrary depth, thresholds, REG/FWFT read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 5,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               enq,
    output logic                               full_n,
    output logic [DATA_WIDTH-1:0]              dout,
    input  logic                               deq,
    output logic                               empty_n,
    input  logic                               clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF    = c_CNT_W'(AF_THRESH);
    localparam logic [c_CNT_W-1:0] c_AE    = c_CNT_W'(AE_THRESH);

    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("fifo_flex: FIFO_DEPTH must be at least 2");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH)) begin : g_chk_thresh
        $error("fifo_flex: require AE_THRESH < AF_THRESH <= FIFO_DEPTH");
    end

    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]    count_q, count_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  w_enq_acc, w_deq_acc;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign full_n    = (count_q != c_DEPTH);
    assign empty_n   = (count_q != '0);
    assign w_enq_acc = enq & full_n;
    assign w_deq_acc = deq & empty_n;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (w_enq_acc) begin
                wr_ptr_d = c_PTR_W'(ptr_wrap(32'(wr_ptr_q), FIFO_DEPTH));
            end
            if (w_deq_acc) begin
                rd_ptr_d = c_PTR_W'(ptr_wrap(32'(rd_ptr_q), FIFO_DEPTH));
            end
            case ({w_enq_acc, w_deq_acc})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (enq & ~full_n);
            udf_d = udf_q | (deq & ~empty_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (c_PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (w_enq_acc & ~clr & ~rst),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (din),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_rd_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign dout = w_rd_data;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q;
        // A dequeue dropped by clr must not disturb the held output word.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (w_deq_acc && !clr) begin
                dout_q <= w_rd_data;
            end
        end
        assign dout = dout_q;
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= c_AF);
    assign almost_empty = (count_q <= c_AE);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
`default_nettype wire
